// File: rtl/operand_bypass_scoreboard.sv
// operand_bypass_scoreboard
//   Operand forwarding for NUM_RS read ports from NUM_FWD pipeline stages, plus a
//   register scoreboard for long-latency results (load miss, DIV, CSR) that come
//   back through the out-of-band writeback port.
//   Optional: define BYPASS_STALL_CNT_EN to add a saturating stall-cycle counter
//   (stall_cnt output, stall_cnt_clr input).
module operand_bypass_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_RS   = 2,
    parameter int NUM_FWD  = 2,
    parameter int MAX_PEND = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RS*5-1:0]           rs_addr,
    input  logic [NUM_RS*XLEN-1:0]        rs_rdata,
    output logic [NUM_RS*XLEN-1:0]        fwd_rs_rdata,
    input  logic [NUM_FWD*5-1:0]          fwd_rd,
    input  logic [NUM_FWD-1:0]            fwd_we,
    input  logic [NUM_FWD-1:0]            fwd_en,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic                          iss_fire,
    input  logic                          iss_long,
    input  logic [4:0]                    iss_rd,
    output logic                          iss_ready,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_rd,
    input  logic [XLEN-1:0]               wb_data,
    output logic                          alu_force_stall,
`ifdef BYPASS_STALL_CNT_EN
    input  logic                          stall_cnt_clr,
    output logic [31:0]                   stall_cnt,
`endif
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PEND);

    logic [31:0]       pending;
    logic [31:0]       pend_nxt;
    logic [NUM_RS-1:0] port_stall;
    logic              set_hit;
    logic              clr_hit;
    logic              wb_hit_iss;

    // Per read port: pick the forwarded operand and flag operand hazards.
    for (genvar i = 0; i < NUM_RS; i++) begin : g_port
        logic [4:0]      a;
        logic            hit;
        logic            hit_vld;
        logic            wb_hit;
        logic [XLEN-1:0] hit_data;
        logic [XLEN-1:0] sel;
        logic            ps;

        assign a = rs_addr[i*5 +: 5];

        // Scan oldest to youngest so the lowest-index (youngest) match wins.
        always_comb begin
            hit      = 1'b0;
            hit_vld  = 1'b1;
            hit_data = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_en[k] && fwd_we[k] && fwd_rd[k*5 +: 5] == a) begin
                    hit      = 1'b1;
                    hit_vld  = fwd_valid[k];
                    hit_data = fwd_data[k*XLEN +: XLEN];
                end
            end
            wb_hit = wb_valid && (wb_rd == a);
            if (a == 5'd0)   sel = '0;
            else if (hit)    sel = hit_data;
            else if (wb_hit) sel = wb_data;
            else             sel = rs_rdata[i*XLEN +: XLEN];
            // x0 never forwards, so a stage writing x0 cannot stall it.
            ps = ((a != 5'd0) && hit && !hit_vld) || (pending[a] && !wb_hit);
        end

        assign fwd_rs_rdata[i*XLEN +: XLEN] = sel;
        assign port_stall[i]               = ps;
    end

    assign set_hit    = iss_fire && iss_long && (iss_rd != 5'd0);
    // Only a return to a register actually pending retires an outstanding op.
    assign clr_hit    = wb_valid && (wb_rd != 5'd0) && pending[wb_rd];
    assign wb_hit_iss = wb_valid && (wb_rd == iss_rd);
    assign iss_ready  = (pend_cnt < MAX_C) || ((pend_cnt == MAX_C) && clr_hit);

    assign alu_force_stall = (|port_stall)
                           || (iss_long && pending[iss_rd] && !wb_hit_iss)
                           || (iss_long && !iss_ready);

    // Next bitmap: clear on return first so a same-rd issue overrides it.
    always_comb begin
        pend_nxt = pending;
        if (wb_valid) pend_nxt[wb_rd] = 1'b0;
        if (set_hit)  pend_nxt[iss_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard state: pending bitmap and saturating outstanding-op count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending <= pend_nxt;
            if (set_hit && !clr_hit && pend_cnt != MAX_C)
                pend_cnt <= pend_cnt + CW'(1);
            else if (clr_hit && !set_hit && pend_cnt != '0)
                pend_cnt <= pend_cnt - CW'(1);
        end
    end

`ifdef BYPASS_STALL_CNT_EN
    // Saturating count of stalled cycles; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_cnt_clr)
            stall_cnt <= '0;
        else if (alu_force_stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
